// File: rtl/instr_mem_ctrl_pkg.sv
// Shared definitions for the instruction-memory responder: AHB encodings,
// AHB read-master state type and an address alignment helper.
package instr_mem_ctrl_pkg;

  localparam int ADDR_WIDTH  = 32;
  localparam int INSTR_WIDTH = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_INSTR   = 4'b0010;

  typedef enum logic [1:0] {
    AHB_IDLE = 2'd0,
    AHB_ADDR = 2'd1,
    AHB_DATA = 2'd2,
    AHB_RESP = 2'd3
  } ahb_state_e;

  // Instruction fetches are always word transfers, so byte offset bits are dropped.
  function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] a);
    return {a[ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_mem_ctrl_ahb_rd_master.sv
// Single non-sequential AHB-Lite word read per start pulse; captures HRDATA/HRESP
// on the completing data-phase cycle and presents them for one response cycle.
module instr_mem_ctrl_ahb_rd_master
  import instr_mem_ctrl_pkg::*;
(
  input  logic                   cpu_clk,
  input  logic                   cpu_rstn,
  input  logic                   start_i,
  input  logic [ADDR_WIDTH-1:0]  addr_i,
  output logic [ADDR_WIDTH-1:0]  haddr_o,
  output logic [1:0]             htrans_o,
  input  logic [INSTR_WIDTH-1:0] hrdata_i,
  input  logic                   hready_i,
  input  logic                   hresp_i,
  output logic                   busy_o,
  output logic                   resp_vld_o,
  output logic [INSTR_WIDTH-1:0] rdata_o,
  output logic                   err_o
);

  ahb_state_e             state_q, state_d;
  logic [INSTR_WIDTH-1:0] hrdata_q;
  logic                   herr_q;

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q  <= AHB_IDLE;
      hrdata_q <= '0;
      herr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == AHB_DATA && hready_i) begin
        hrdata_q <= hrdata_i;
        herr_q   <= hresp_i;
      end
    end
  end

  // A new request accepted in the response cycle goes straight to a fresh address phase.
  always_comb begin
    state_d    = state_q;
    htrans_o   = HTRANS_IDLE;
    busy_o     = 1'b0;
    resp_vld_o = 1'b0;
    unique case (state_q)
      AHB_IDLE: if (start_i) state_d = AHB_ADDR;
      AHB_ADDR: begin
        htrans_o = HTRANS_NONSEQ;
        busy_o   = 1'b1;
        if (hready_i) state_d = AHB_DATA;
      end
      AHB_DATA: begin
        busy_o = 1'b1;
        if (hready_i) state_d = AHB_RESP;
      end
      AHB_RESP: begin
        busy_o     = 1'b1;
        resp_vld_o = 1'b1;
        state_d    = start_i ? AHB_ADDR : AHB_IDLE;
      end
      default: state_d = AHB_IDLE;
    endcase
  end

  assign haddr_o = word_align(addr_i);
  assign rdata_o = (resp_vld_o && !herr_q) ? hrdata_q : '0;
  assign err_o   = resp_vld_o & herr_q;

endmodule

// File: rtl/instr_mem_ctrl.sv
// Fetch-side instruction memory responder: decodes next_pc to ITCM or AHB,
// accepts one request per returned instruction, and returns words in order.
module instr_mem_ctrl
  import instr_mem_ctrl_pkg::*;
#(
  parameter logic [31:0] ITCM_BASE = 32'h0000_0000,
  parameter int          ITCM_AW   = 12
) (
  input  logic                   cpu_clk,
  input  logic                   cpu_rstn,
  input  logic [ADDR_WIDTH-1:0]  next_pc,
  output logic                   instr_read_data_valid,
  output logic [INSTR_WIDTH-1:0] instr_read_data,
  output logic                   addr_AHB,
  output logic                   instr_access_fault,
  output logic                   itcm_cs,
  output logic [ITCM_AW-1:0]     itcm_addr,
  input  logic [INSTR_WIDTH-1:0] itcm_rdata,
  output logic [ADDR_WIDTH-1:0]  HADDR,
  output logic [1:0]             HTRANS,
  output logic [2:0]             HSIZE,
  output logic [2:0]             HBURST,
  output logic [3:0]             HPROT,
  output logic                   HWRITE,
  input  logic [INSTR_WIDTH-1:0] HRDATA,
  input  logic                   HREADY,
  input  logic                   HRESP
);

  logic                   boot_q;
  logic                   itcm_vld_q, itcm_vld_d;
  logic [ADDR_WIDTH-1:0]  req_addr_q, req_addr_d;
  logic                   itcm_hit, accept, ahb_start;
  logic                   ahb_busy, ahb_vld, ahb_err;
  logic [INSTR_WIDTH-1:0] ahb_rdata;

  assign itcm_hit = (next_pc[31:ITCM_AW+2] == ITCM_BASE[31:ITCM_AW+2]);

  // boot_q marks the single idle cycle after reset; it is qualified by cpu_rstn so
  // that no ITCM read is issued while reset is still asserted.
  assign accept    = (boot_q & cpu_rstn) | instr_read_data_valid;
  assign ahb_start = accept & ~itcm_hit;

  always_comb begin
    req_addr_d = req_addr_q;
    itcm_vld_d = accept & itcm_hit;
    if (accept) req_addr_d = next_pc;
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      boot_q     <= 1'b1;
      itcm_vld_q <= 1'b0;
      req_addr_q <= '0;
    end else begin
      boot_q     <= 1'b0;
      itcm_vld_q <= itcm_vld_d;
      req_addr_q <= req_addr_d;
    end
  end

  instr_mem_ctrl_ahb_rd_master u_ahb_rd_master (
    .cpu_clk    (cpu_clk),
    .cpu_rstn   (cpu_rstn),
    .start_i    (ahb_start),
    .addr_i     (req_addr_q),
    .haddr_o    (HADDR),
    .htrans_o   (HTRANS),
    .hrdata_i   (HRDATA),
    .hready_i   (HREADY),
    .hresp_i    (HRESP),
    .busy_o     (ahb_busy),
    .resp_vld_o (ahb_vld),
    .rdata_o    (ahb_rdata),
    .err_o      (ahb_err)
  );

  assign itcm_cs   = accept & itcm_hit;
  assign itcm_addr = next_pc[ITCM_AW+1:2];

  assign instr_read_data_valid = itcm_vld_q | ahb_vld;
  assign instr_read_data       = itcm_vld_q ? itcm_rdata : ahb_rdata;
  assign instr_access_fault    = ahb_err;
  assign addr_AHB              = ahb_busy;

  assign HSIZE  = HSIZE_WORD;
  assign HBURST = HBURST_SINGLE;
  assign HPROT  = HPROT_INSTR;
  assign HWRITE = 1'b0;

endmodule
